// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the FIR coefficient loader.
// FLUSH is only reachable when FIR_TAP_LOADER_FLUSH_EN is defined.
package fir_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Cycles needed to push zeros through both sample delays and the product/acc stages of every tap
  function automatic int unsigned flush_len(input int unsigned ntaps);
    return 2 * ntaps + 2;
  endfunction

  // Bits needed to hold any value in 0..n
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_flush_ctr.sv
// Down-counter that times the FIR chain flush; done_c marks the final flush cycle.
module fir_flush_ctr
  import fir_pkg::*;
#(
  parameter int unsigned LEN = 34
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done_c
);

  localparam int unsigned FW = cnt_width(LEN);

  logic [FW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= FW'(LEN);
    end else if (en && cnt != '0) begin
      cnt <= cnt - FW'(1);
    end
  end

  assign done_c = en && (cnt == FW'(1));

endmodule

// File: rtl/fir_tap_loader.sv
// Coefficient loader and sample-enable gate in front of a firtap chain.
// Optional post-load chain flush enabled by defining FIR_TAP_LOADER_FLUSH_EN.
module fir_tap_loader
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS = 16,
  parameter int unsigned IW    = 16,
  parameter int unsigned TW    = IW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [TW-1:0] i_coeff,
  input  logic          i_last,
  output logic          o_tap_wr,
  output logic [TW-1:0] o_tap,
  input  logic          i_ce,
  input  logic [IW-1:0] i_sample,
  output logic          o_ce,
  output logic [IW-1:0] o_sample,
  output logic          o_busy,
  output logic          o_loaded,
  output logic          o_err
);

  localparam int unsigned   CW       = cnt_width(NTAPS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NTAPS - 1);

  state_t        state, state_d;
  logic [CW-1:0] count, count_d;
  logic          ready_d, tap_wr_d, ce_d, busy_d, loaded_d, err_d;
  logic [TW-1:0] tap_d;
  logic [IW-1:0] sample_d;
  logic          accept_c, end_beat_c;

`ifdef FIR_TAP_LOADER_FLUSH_EN
  logic flush_load_c, flush_done_c;

  fir_flush_ctr #(
    .LEN (flush_len(NTAPS))
  ) u_flush_ctr (
    .clk    (i_clk),
    .rst    (i_reset),
    .load   (flush_load_c),
    .en     (state == FLUSH),
    .done_c (flush_done_c)
  );
`endif

  // A beat ends the load on i_last or when the count reaches the chain length
  assign accept_c   = i_valid && o_ready;
  assign end_beat_c = i_last || (count == LAST_IDX);

  always_comb begin
    state_d  = state;
    count_d  = count;
    loaded_d = o_loaded;
    err_d    = o_err;
    tap_wr_d = 1'b0;
    tap_d    = o_tap;
    ce_d     = 1'b0;
    sample_d = o_sample;
`ifdef FIR_TAP_LOADER_FLUSH_EN
    flush_load_c = 1'b0;
`endif
    case (state)
      IDLE: begin
        ce_d = i_ce && o_loaded;
        if (i_ce) sample_d = i_sample;
        if (i_start) begin
          state_d  = LOAD;
          count_d  = '0;
          loaded_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      LOAD: begin
        if (i_ce) sample_d = i_sample;
        if (accept_c) begin
          tap_wr_d = 1'b1;
          tap_d    = i_coeff;
          count_d  = count + CW'(1);
          if (end_beat_c) begin
            if (i_last && count == LAST_IDX) begin
`ifdef FIR_TAP_LOADER_FLUSH_EN
              state_d      = FLUSH;
              flush_load_c = 1'b1;
`else
              state_d  = IDLE;
              loaded_d = 1'b1;
`endif
            end else begin
              state_d  = IDLE;
              loaded_d = 1'b0;
              err_d    = 1'b1;
            end
          end
        end
      end
`ifdef FIR_TAP_LOADER_FLUSH_EN
      FLUSH: begin
        ce_d     = 1'b1;
        sample_d = '0;
        if (flush_done_c) begin
          state_d  = IDLE;
          loaded_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      count    <= '0;
      o_ready  <= 1'b0;
      o_tap_wr <= 1'b0;
      o_tap    <= '0;
      o_ce     <= 1'b0;
      o_sample <= '0;
      o_busy   <= 1'b0;
      o_loaded <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      o_ready  <= ready_d;
      o_tap_wr <= tap_wr_d;
      o_tap    <= tap_d;
      o_ce     <= ce_d;
      o_sample <= sample_d;
      o_busy   <= busy_d;
      o_loaded <= loaded_d;
      o_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Randomized scoreboard bench for fir_tap_loader: expected tap writes and gated
// samples are queued at stimulus time and popped by an independent monitor.
module tb_fir_tap_loader;
  import fir_pkg::*;

  localparam int unsigned NTAPS = 16;
  localparam int unsigned IW    = 16;
  localparam int unsigned TW    = 16;
  localparam int unsigned FL    = flush_len(NTAPS);
`ifdef FIR_TAP_LOADER_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic          i_clk, i_reset, i_start, i_valid, i_last, i_ce;
  logic [TW-1:0] i_coeff;
  logic [IW-1:0] i_sample;
  logic          o_ready, o_tap_wr, o_ce, o_busy, o_loaded, o_err;
  logic [TW-1:0] o_tap;
  logic [IW-1:0] o_sample;

  fir_tap_loader #(.NTAPS(NTAPS), .IW(IW), .TW(TW)) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_coeff  (i_coeff),
    .i_last   (i_last),
    .o_tap_wr (o_tap_wr),
    .o_tap    (o_tap),
    .i_ce     (i_ce),
    .i_sample (i_sample),
    .o_ce     (o_ce),
    .o_sample (o_sample),
    .o_busy   (o_busy),
    .o_loaded (o_loaded),
    .o_err    (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] tap_q[$];
  logic [IW-1:0] samp_q[$];
  bit model_loaded = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  // Monitor: every tap write and every chain strobe must match the head of its queue
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_tap_wr) begin
        if (tap_q.size() == 0) fail_now("tap_wr", "unexpected tap write");
        else check("tap_value", o_tap, tap_q.pop_front());
      end
      if (o_ce) begin
        if (samp_q.size() == 0) fail_now("ce", "unexpected o_ce");
        else check("sample_value", o_sample, samp_q.pop_front());
      end
      if (o_tap_wr || o_ce) check("tap_wr_ce_exclusive", o_tap_wr && o_ce, 0);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, o_ready, 0);
    check({tag, "_tap_wr"}, o_tap_wr, 0);
    check({tag, "_tap"}, o_tap, 0);
    check({tag, "_ce"}, o_ce, 0);
    check({tag, "_sample"}, o_sample, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_loaded"}, o_loaded, 0);
    check({tag, "_err"}, o_err, 0);
  endtask

  // Reset asserted mid-cycle: outputs must clear before the next edge
  task automatic do_reset_mid();
    @(posedge i_clk);
    #3 i_reset = 1'b1;
    #1 check_all_zero("async_reset");
    tap_q.delete();
    samp_q.delete();
    model_loaded = 1'b0;
    i_valid = 1'b0; i_start = 1'b0; i_ce = 1'b0; i_last = 1'b0;
    repeat (2) @(posedge i_clk);
    #2 i_reset = 1'b0;
    tick();
  endtask

  task automatic send_beat(input logic [TW-1:0] c, input bit last, output bit ok);
    bit acc;
    ok = 1'b0;
    i_valid = 1'b1;
    i_coeff = c;
    i_last  = last;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      acc = o_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (!ok) fail_now("beat_accept", "o_ready never seen");
  endtask

  // One load: last_at = beat index carrying i_last (-1 = none); nsend >= 0 stops early (abort)
  task automatic load_set(input int last_at, input bit noise, input int nsend);
    int n;
    bit good, ok;
    logic [TW-1:0] c;
    n    = (last_at >= 0 && last_at < int'(NTAPS)) ? last_at + 1 : int'(NTAPS);
    good = (last_at == int'(NTAPS) - 1);
    if (nsend >= 0) n = nsend;
    model_loaded = 1'b0;
    i_ce = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int b = 0; b < n; b++) begin
      repeat ($urandom_range(0, 2)) begin
        i_valid = 1'b0;
        if (noise) i_start = 1'($urandom % 2);
        i_ce = 1'($urandom % 2);
        i_sample = IW'($urandom);
        tick();
      end
      if (noise) i_start = 1'($urandom % 2);
      i_ce = 1'($urandom % 2);
      c = TW'($urandom);
      send_beat(c, b == last_at, ok);
      if (ok) tap_q.push_back(c);
    end
    i_start = 1'b0;
    i_ce = 1'b0;
    if (nsend >= 0) return;
    if (good && FLUSH_ON) begin
      for (int k = 0; k < int'(FL); k++) samp_q.push_back('0);
      repeat (FL) begin
        i_ce = 1'($urandom % 2);
        i_sample = IW'($urandom) | IW'(1);
        tick();
      end
    end
    // First cycle back in IDLE: a sample here is accepted only after a good load
    i_ce = 1'($urandom % 2);
    i_sample = IW'($urandom);
    if (good && i_ce) samp_q.push_back(i_sample);
    @(negedge i_clk);
    check("loaded_after_load", o_loaded, good);
    check("err_after_load", o_err, !good);
    check("busy_after_load", o_busy, 0);
    check("ready_after_load", o_ready, 0);
    tick();
    i_ce = 1'b0;
    model_loaded = good;
  endtask

  task automatic sample_phase(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      i_ce = ($urandom % 4) != 0;
      i_sample = IW'($urandom);
      if (i_ce && model_loaded) samp_q.push_back(i_sample);
      tick();
    end
    i_ce = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    i_ce = 1'b0; i_coeff = '0; i_sample = '0;
    repeat (3) @(posedge i_clk);
    #2 i_reset = 1'b0;
    @(negedge i_clk);
    check_all_zero("por");
    tick();

    // Good load, then gated sample stream
    load_set(NTAPS - 1, 1'b0, -1);
    sample_phase(40);

    // Asynchronous reset while loaded
    do_reset_mid();
    load_set(NTAPS - 1, 1'b0, -1);
    sample_phase(20);

    // Early i_last: error, samples dropped
    load_set(4, 1'b0, -1);
    sample_phase(20);

    // Full count without i_last: error and no further beats accepted
    load_set(-1, 1'b0, -1);
    i_valid = 1'b1;
    i_coeff = TW'($urandom);
    repeat (3) begin
      @(negedge i_clk);
      check("ready_after_overrun", o_ready, 0);
      tick();
    end
    i_valid = 1'b0;
    sample_phase(10);

    // Back-pressure gaps with stray starts, then a reset mid-load and a clean restart
    load_set(NTAPS - 1, 1'b1, -1);
    sample_phase(20);
    load_set(-1, 1'b1, 8);
    do_reset_mid();
    @(negedge i_clk);
    check("loaded_after_abort", o_loaded, 0);
    tick();
    load_set(NTAPS - 1, 1'b1, -1);
    sample_phase(30);

    repeat (3) begin
      load_set(NTAPS - 1, 1'($urandom % 2), -1);
      sample_phase(15);
    end

    repeat (5) tick();
    check("tap_queue_drained", tap_q.size(), 0);
    check("sample_queue_drained", samp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
